// File: rtl/mac_tx_frame_arbiter.sv
// Frame-level round-robin arbiter in front of the MAC's AXI-Stream TX port.
// A grant is held from the first beat until the tlast handshake, so frames from
// different sources never interleave. Between frames there is one idle cycle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no grant; pick the next requester after the last-grant pointer
// XFER  | granted source is muxed straight through to the MAC until tlast

module mac_tx_frame_arbiter #(
   parameter int N_SRC     = 4,
   parameter int N_SYMBOLS = 8,
   parameter int W_SYMBOL  = 8,
   parameter int W_CNT     = 32
) (
   input  logic                                  i_clk,
   input  logic                                  i_reset_n,
   input  logic                                  i_enable,
   input  logic [N_SRC-1:0]                      s_axis_tvalid,
   input  logic [N_SRC*N_SYMBOLS*W_SYMBOL-1:0]   s_axis_tdata,
   input  logic [N_SRC*N_SYMBOLS-1:0]            s_axis_tkeep,
   input  logic [N_SRC-1:0]                      s_axis_tlast,
   output logic [N_SRC-1:0]                      s_axis_tready,
   output logic                                  m_axis_tvalid,
   output logic [N_SYMBOLS*W_SYMBOL-1:0]         m_axis_tdata,
   output logic [N_SYMBOLS-1:0]                  m_axis_tkeep,
   output logic                                  m_axis_tlast,
   input  logic                                  m_axis_tready,
   output logic [N_SRC-1:0]                      o_grant,
   output logic                                  o_busy,
   output logic [W_CNT-1:0]                      o_frame_cnt
);

   localparam int W_DATA = N_SYMBOLS * W_SYMBOL;
   localparam int W_PTR  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   typedef enum logic {IDLE, XFER} state_t;

   state_t             state_q;
   logic [N_SRC-1:0]   grant_q;
   logic [W_PTR-1:0]   gidx_q;
   logic [W_PTR-1:0]   ptr_q;
   logic               busy_q;
   logic [W_CNT-1:0]   cnt_q;

   logic               win_vld;
   logic [W_PTR-1:0]   win_idx;
   logic               frame_end;

   // Round-robin search: first requester scanning upward from ptr+1, wrapping.
   always_comb begin
      int idx;
      idx     = 0;
      win_vld = 1'b0;
      win_idx = ptr_q;
      for (int i = 1; i <= N_SRC; i++) begin
         idx = (int'(ptr_q) + i) % N_SRC;
         if (!win_vld && s_axis_tvalid[W_PTR'(idx)]) begin
            win_vld = 1'b1;
            win_idx = W_PTR'(idx);
         end
      end
   end

   // Pass-through mux of the granted source; everything quiet while idle.
   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      if (state_q == XFER) begin
         m_axis_tvalid         = s_axis_tvalid[gidx_q];
         m_axis_tdata          = s_axis_tdata[int'(gidx_q)*W_DATA +: W_DATA];
         m_axis_tkeep          = s_axis_tkeep[int'(gidx_q)*N_SYMBOLS +: N_SYMBOLS];
         m_axis_tlast          = s_axis_tlast[gidx_q];
         s_axis_tready[gidx_q] = m_axis_tready;
      end
   end

   assign frame_end = (state_q == XFER) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

   // Grant FSM: enable is only looked at in IDLE, so a frame is never cut short.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= W_PTR'(N_SRC - 1);
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_enable && win_vld) begin
                  state_q <= XFER;
                  grant_q <= N_SRC'(1) << win_idx;
                  gidx_q  <= win_idx;
                  busy_q  <= 1'b1;
               end
            end
            XFER: begin
               if (frame_end) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  ptr_q   <= gidx_q;
                  busy_q  <= 1'b0;
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_grant     = grant_q;
   assign o_busy      = busy_q;
   assign o_frame_cnt = cnt_q;

endmodule

// File: tb/tb_mac_tx_frame_arbiter.sv
// Directed bench for mac_tx_frame_arbiter (4 sources, 64-bit beats).
module tb_mac_tx_frame_arbiter;

   localparam int N  = 4;
   localparam int NS = 8;
   localparam int WS = 8;
   localparam int WD = NS * WS;
   localparam int WC = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic [N-1:0]      s_tvalid;
   logic [N*WD-1:0]   s_tdata;
   logic [N*NS-1:0]   s_tkeep;
   logic [N-1:0]      s_tlast;
   logic [N-1:0]      s_tready;
   logic              m_tvalid;
   logic [WD-1:0]     m_tdata;
   logic [NS-1:0]     m_tkeep;
   logic              m_tlast;
   logic              m_tready;
   logic [N-1:0]      grant;
   logic              busy;
   logic [WC-1:0]     fcnt;

   mac_tx_frame_arbiter #(.N_SRC(N), .N_SYMBOLS(NS), .W_SYMBOL(WS), .W_CNT(WC)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_enable(en),
      .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
      .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
      .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
      .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
      .o_grant(grant), .o_busy(busy), .o_frame_cnt(fcnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        rst;
      bit        en;
      bit [3:0]  sv;
      bit [3:0]  sl;
      bit [7:0]  keep;
      bit        mr;
      bit        mv;
      bit        ml;
      bit [3:0]  gr;
      bit        busy;
      bit [3:0]  sr;
      int        cnt;
   } vec_t;

   vec_t tv[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] dword(input int s, input int k);
      return {32'hA500_0000 | 32'(s), 32'(k)};
   endfunction

   function automatic void row(input bit rst, input bit e, input bit [3:0] sv, input bit [3:0] sl,
                               input bit [7:0] keep, input bit mr, input bit mv, input bit ml,
                               input bit [3:0] gr, input bit b, input bit [3:0] sr, input int cnt);
      vec_t v;
      v.rst = rst; v.en = e; v.sv = sv; v.sl = sl; v.keep = keep; v.mr = mr;
      v.mv = mv; v.ml = ml; v.gr = gr; v.busy = b; v.sr = sr; v.cnt = cnt;
      tv.push_back(v);
   endfunction

   // Apply inputs just after a rising edge, then settle to mid-cycle for sampling.
   task automatic drive(input logic e, input logic [3:0] sv, input logic [3:0] sl,
                        input logic [7:0] keep, input logic mr, input int tag);
      @(posedge clk);
      #1;
      en       = e;
      s_tvalid = sv;
      s_tlast  = sl;
      for (int s = 0; s < N; s++) begin
         s_tdata[s*WD +: WD] = dword(s, tag);
         s_tkeep[s*NS +: NS] = keep;
      end
      m_tready = mr;
      #4;
   endtask

   task automatic do_reset();
      #1;
      rst_n    = 1'b0;
      s_tvalid = '0;
      s_tlast  = '0;
      #2;
      rst_n    = 1'b1;
   endtask

   int order[5] = '{0, 1, 2, 3, 0};

   initial begin
      int beat;
      int src;
      logic [63:0] rx[$];
      logic [3:0]  g;

      rst_n = 1'b0; en = 1'b0; s_tvalid = '0; s_tdata = '0; s_tkeep = '0;
      s_tlast = '0; m_tready = 1'b0;
      #2;
      chk("rst grant", 64'(grant), 64'h0);
      chk("rst busy", 64'(busy), 64'h0);
      chk("rst cnt", 64'(fcnt), 64'h0);
      chk("rst mvalid", 64'(m_tvalid), 64'h0);
      chk("rst sready", 64'(s_tready), 64'h0);
      #3;
      rst_n = 1'b1;

      // 3-beat frame from src1
      row(1,1,4'b0010,4'b0000,8'hFF,1, 0,0,4'b0000,0,4'b0000,0);
      row(0,1,4'b0010,4'b0000,8'hFF,1, 1,0,4'b0010,1,4'b0010,0);
      row(0,1,4'b0010,4'b0000,8'hFF,1, 1,0,4'b0010,1,4'b0010,0);
      row(0,1,4'b0010,4'b0010,8'h0F,1, 1,1,4'b0010,1,4'b0010,0);
      row(0,1,4'b0000,4'b0000,8'hFF,1, 0,0,4'b0000,0,4'b0000,1);
      // all four sources with back-to-back 2-beat frames
      row(1,1,4'b1111,4'b0000,8'hFF,1, 0,0,4'b0000,0,4'b0000,0);
      for (int f = 0; f < 5; f++) begin
         g = 4'(1 << order[f]);
         row(0,1,4'b1111,4'b0000,8'hFF,1, 1,0,g,1,g,f);
         row(0,1,4'b1111,g,      8'hFF,1, 1,1,g,1,g,f);
         if (f < 4) row(0,1,4'b1111,4'b0000,8'hFF,1, 0,0,4'b0000,0,4'b0000,f+1);
      end
      row(0,1,4'b0000,4'b0000,8'hFF,1, 0,0,4'b0000,0,4'b0000,5);
      // src2 locked through its 4-beat frame while src0 requests
      row(1,1,4'b0100,4'b0000,8'hFF,1, 0,0,4'b0000,0,4'b0000,0);
      row(0,1,4'b0100,4'b0000,8'hFF,1, 1,0,4'b0100,1,4'b0100,0);
      row(0,1,4'b0101,4'b0000,8'hFF,1, 1,0,4'b0100,1,4'b0100,0);
      row(0,1,4'b0101,4'b0000,8'hFF,1, 1,0,4'b0100,1,4'b0100,0);
      row(0,1,4'b0101,4'b0100,8'h3F,1, 1,1,4'b0100,1,4'b0100,0);
      row(0,1,4'b0001,4'b0000,8'hFF,1, 0,0,4'b0000,0,4'b0000,1);
      row(0,1,4'b0001,4'b0001,8'h01,1, 1,1,4'b0001,1,4'b0001,1);
      row(0,1,4'b0000,4'b0000,8'hFF,1, 0,0,4'b0000,0,4'b0000,2);

      for (int i = 0; i < tv.size(); i++) begin
         if (tv[i].rst) do_reset();
         drive(tv[i].en, tv[i].sv, tv[i].sl, tv[i].keep, tv[i].mr, i);
         chk($sformatf("r%0d mvalid", i), 64'(m_tvalid), 64'(tv[i].mv));
         chk($sformatf("r%0d mlast", i), 64'(m_tlast), 64'(tv[i].ml));
         chk($sformatf("r%0d grant", i), 64'(grant), 64'(tv[i].gr));
         chk($sformatf("r%0d busy", i), 64'(busy), 64'(tv[i].busy));
         chk($sformatf("r%0d sready", i), 64'(s_tready), 64'(tv[i].sr));
         chk($sformatf("r%0d cnt", i), 64'(fcnt), 64'(tv[i].cnt));
         if (tv[i].mv) begin
            src = 0;
            for (int s = 0; s < N; s++) if (tv[i].gr[s]) src = s;
            chk($sformatf("r%0d tdata", i), m_tdata, dword(src, i));
            chk($sformatf("r%0d tkeep", i), 64'(m_tkeep), 64'(tv[i].keep));
         end
      end

      // MAC backpressure for 5 cycles in the middle of a 4-beat frame from src1
      do_reset();
      drive(1, 4'b0010, 4'b0000, 8'hFF, 1, 0);
      beat = 0;
      for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
         logic mr;
         mr = !(cyc >= 2 && cyc < 7);
         drive(1, 4'b0010, (beat == 3) ? 4'b0010 : 4'b0000, 8'hFF, mr, beat);
         if (m_tvalid && m_tready) rx.push_back(m_tdata);
         if (!mr) begin
            chk("stall tdata", m_tdata, dword(1, 2));
            chk("stall grant", 64'(grant), 64'h2);
            chk("stall sready", 64'(s_tready), 64'h0);
         end
         if (s_tready[1] && s_tvalid[1]) beat++;
      end
      chk("stall beats", 64'(rx.size()), 64'd4);
      for (int k = 0; k < rx.size(); k++) chk($sformatf("stall beat%0d", k), rx[k], dword(1, k));
      drive(1, 4'b0000, 4'b0000, 8'hFF, 1, 0);
      chk("stall busy", 64'(busy), 64'h0);
      chk("stall cnt", 64'(fcnt), 64'd1);

      // enable dropped on beat 1 of a src0 frame with src1 pending
      do_reset();
      drive(1, 4'b0011, 4'b0000, 8'hFF, 1, 0);
      chk("en idle busy", 64'(busy), 64'h0);
      for (int k = 0; k < 4; k++) begin
         drive(0, 4'b0011, (k == 3) ? 4'b0001 : 4'b0000, 8'hFF, 1, k);
         chk($sformatf("en beat%0d grant", k), 64'(grant), 64'h1);
         chk($sformatf("en beat%0d mvalid", k), 64'(m_tvalid), 64'h1);
      end
      for (int k = 0; k < 3; k++) begin
         drive(0, 4'b0010, 4'b0000, 8'hFF, 1, 0);
         chk($sformatf("en off%0d busy", k), 64'(busy), 64'h0);
         chk($sformatf("en off%0d grant", k), 64'(grant), 64'h0);
      end
      chk("en cnt", 64'(fcnt), 64'd1);
      drive(1, 4'b0010, 4'b0010, 8'hFF, 1, 0);
      chk("en back busy", 64'(busy), 64'h0);
      drive(1, 4'b0010, 4'b0010, 8'hFF, 1, 0);
      chk("en resume grant", 64'(grant), 64'h2);
      chk("en resume mlast", 64'(m_tlast), 64'h1);

      // reset in the middle of a frame, counter non-zero beforehand
      drive(1, 4'b1111, 4'b0000, 8'hFF, 1, 0);
      chk("mid cnt before", 64'(fcnt), 64'd2);
      drive(1, 4'b1111, 4'b0000, 8'hFF, 1, 0);
      chk("mid grant src2", 64'(grant), 64'h4);
      rst_n = 1'b0;
      #1;
      chk("mid rst grant", 64'(grant), 64'h0);
      chk("mid rst busy", 64'(busy), 64'h0);
      chk("mid rst cnt", 64'(fcnt), 64'h0);
      chk("mid rst mvalid", 64'(m_tvalid), 64'h0);
      chk("mid rst sready", 64'(s_tready), 64'h0);
      #1;
      rst_n = 1'b1;
      drive(1, 4'b1111, 4'b0000, 8'hFF, 1, 0);
      chk("post rst grant", 64'(grant), 64'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mac_tx_frame_arbiter.md
Name: mac_tx_frame_arbiter

Overview:
- Frame-level round-robin arbiter sharing the single AXI-Stream TX input of the 10G MAC/PCS datapath among N_SRC independent frame sources (e.g. host DMA, control/pause generator, loopback test generator).
- Grants one source at a time and holds the grant until that source's tlast handshake, so frames never interleave at the MAC.
- Sits directly upstream of the MAC's slave AXI-Stream port. The MAC's tready, already gated by the PCS clock-enable, provides all backpressure.

Parameters:
- N_SRC, 4, number of requesting AXI-Stream sources (2..8).
- N_SYMBOLS, 8, bytes per beat (matches cmn_params).
- W_SYMBOL, 8, bits per symbol (matches cmn_params).
- W_CNT, 32, width of the transmitted-frame counter.

Ports:
- i_clk  in  1  datapath clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  1 = new grants allowed; 0 = finish the current frame, then stop granting.
- s_axis_tvalid  in  N_SRC  per-source valid.
- s_axis_tdata  in  N_SRC x N_SYMBOLS x W_SYMBOL  per-source data.
- s_axis_tkeep  in  N_SRC x N_SYMBOLS  per-source byte keep.
- s_axis_tlast  in  N_SRC  per-source end of frame.
- s_axis_tready  out  N_SRC  per-source ready.
- m_axis_tvalid  out  1  to MAC.
- m_axis_tdata  out  N_SYMBOLS x W_SYMBOL  to MAC.
- m_axis_tkeep  out  N_SYMBOLS  to MAC.
- m_axis_tlast  out  1  to MAC.
- m_axis_tready  in  1  from MAC.
- o_grant  out  N_SRC  one-hot current grant; all zero when idle.
- o_busy  out  1  1 while in XFER.
- o_frame_cnt  out  W_CNT  completed frames across all sources; wraps.

Behaviour:
- The clock is i_clk. The reset is i_reset_n, asynchronous assert, active-low, with synchronous deassert handled upstream.
- Reset values:
  - state = IDLE
  - o_grant = 0, o_busy = 0
  - last-grant pointer = N_SRC-1, so source 0 has first priority
  - o_frame_cnt = 0
  - m_axis_tvalid = 0, s_axis_tready = 0
- FSM has two states, IDLE and XFER.
- IDLE:
  - m_axis_tvalid = 0 and all s_axis_tready = 0.
  - If i_enable = 1 and any s_axis_tvalid bit is set, the winner is the first requesting index found by scanning upward from (pointer+1) mod N_SRC.
  - On that edge, register the one-hot grant and go to XFER.
- Arbitration latency is one cycle: source valid at edge k gives m_axis_tvalid at cycle k+1 at the earliest.
- XFER datapath:
  - m_axis_tvalid/tdata/tkeep/tlast are a combinational mux of the granted source.
  - s_axis_tready[g] = m_axis_tready; every other s_axis_tready bit = 0.
  - No registering and no data modification.
- Frame end:
  - A handshake (m_axis_tvalid & m_axis_tready) with m_axis_tlast = 1 moves the FSM to IDLE.
  - The same edge sets pointer = g, clears o_grant and increments o_frame_cnt, wrapping at 2^W_CNT-1 to 0.
- There is one idle bubble cycle between frames. This is acceptable: the MAC inserts the IPG anyway.
- Lock: requests from other sources during XFER are ignored until the frame end. The granted source may drop tvalid mid-frame; the grant is held.
- m_axis_tready low: the handshake stalls, all signals are held and the grant is held.
- i_enable:
  - Sampled only in IDLE.
  - Deasserting it during XFER does not truncate the frame.
- Single requester: it is re-granted after every bubble regardless of the pointer.
- All requesters active: frames are granted in strict rotation 0,1,2,3,0,... starting from the pointer reset value.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is abandoned; the MAC side is reset by the same reset.
- o_busy = (state == XFER). o_grant is valid only in XFER.

Test Plan:
- Reset, src1 sends a 3-beat frame (tkeep 0xFF, 0xFF, 0x0F), m_axis_tready = 1 -> o_grant = 0b0010 from the cycle after tvalid; 3 beats reach m_axis unchanged; o_frame_cnt = 1; FSM returns to IDLE after the tlast beat.
- src0..src3 all hold 2-beat frames continuously -> grant order 0,1,2,3,0; one idle cycle between frames; o_frame_cnt = 5 after 5 frames.
- src2 granted on a 4-beat frame, src0 asserts tvalid on beat 2 -> s_axis_tready[0] stays 0 until src2's tlast handshake; src0 is granted next.
- m_axis_tready low for 5 cycles mid-frame -> m_axis outputs stable, o_grant unchanged, no beat lost or duplicated.
- i_enable dropped on beat 1 of a 4-beat frame with another source pending -> frame completes; no new grant while i_enable = 0; grant resumes one cycle after i_enable returns to 1.
- i_reset_n pulsed low mid-frame -> o_grant = 0, o_busy = 0, o_frame_cnt = 0 immediately; after release, src0 wins first when all sources request.
